// File: rtl/stepper_phase_driver.sv
// rtl/stepper_phase_driver.sv - step/direction to unipolar stepper coil pattern with dwell and position
//
// Purpose
//   Turns single-cycle step requests into the 8-entry unipolar coil sequence,
//   either half-step (every entry) or full-step (two-coil entries only). A dwell
//   counter enforces a minimum spacing between accepted steps, and a signed
//   counter tracks absolute position in half-step units. All outputs are
//   registered. COIL[0..3] drive the motor header pins directly.
//
// Parameters
//   MIN_STEP_CYCLES  minimum clock cycles between accepted steps (>= 2)
//   POS_W            width of the signed position counter
//
// Ports
//   CLK100MHZ  in   1      system clock, rising edge
//   RST        in   1      asynchronous active-high reset
//   EN         in   1      1 = coils energised and steps accepted, 0 = coils off
//   STEP       in   1      step request, one request per high cycle
//   DIR        in   1      1 = forward (index +), 0 = reverse (index -)
//   HALF       in   1      1 = half-step, 0 = full-step (two-coil) mode
//   COIL       out  4      coil drive pattern
//   BUSY       out  1      dwell in progress, steps rejected
//   STEP_ERR   out  1      one-cycle pulse when a step request was dropped
//   POS        out  POS_W  signed position in half-step units

module stepper_phase_driver #(
    parameter int MIN_STEP_CYCLES = 100000,
    parameter int POS_W           = 16
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             EN,
    input  logic             STEP,
    input  logic             DIR,
    input  logic             HALF,
    output logic [3:0]       COIL,
    output logic             BUSY,
    output logic             STEP_ERR,
    output logic [POS_W-1:0] POS
);

    // The counter only ever holds MIN_STEP_CYCLES-1 down to 0.
    localparam int CNT_W = (MIN_STEP_CYCLES > 2) ? $clog2(MIN_STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MIN_STEP_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       coil_q, coil_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             dwell_done;
    logic             step_ok;
    logic [2:0]       delta;

    // Unipolar phase sequence; odd entries energise two adjacent coils.
    function automatic logic [3:0] phase_coil(input logic [2:0] i);
        logic [3:0] c;
        case (i)
            3'd0:    c = 4'b0001;
            3'd1:    c = 4'b0011;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0100;
            3'd5:    c = 4'b1100;
            3'd6:    c = 4'b1000;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            pos_q   <= '0;
            cnt_q   <= '0;
            coil_q  <= 4'b0000;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            coil_q  <= coil_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // The last dwell cycle doubles as an idle cycle so that steps spaced
    // exactly MIN_STEP_CYCLES apart are accepted without a gap.
    assign dwell_done = (state_q == ST_DWELL) && (cnt_q == '0);
    assign step_ok    = STEP && EN && ((state_q == ST_IDLE) || dwell_done);

    // Full-step from an even (single-coil) entry moves one to reach a two-coil
    // entry; from then on it moves two so it stays on two-coil entries.
    assign delta = (HALF || !idx_q[0]) ? 3'd1 : 3'd2;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        coil_d  = EN ? phase_coil(idx_q) : 4'b0000;

        // The dwell keeps running regardless of EN.
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_DWELL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (step_ok) begin
            if (DIR) begin
                idx_d = idx_q + delta;
                pos_d = pos_q + POS_W'(delta);
            end else begin
                idx_d = idx_q - delta;
                pos_d = pos_q - POS_W'(delta);
            end
            coil_d  = phase_coil(idx_d);
            cnt_d   = CNT_RELOAD;
            busy_d  = 1'b1;
            state_d = ST_DWELL;
        end else if (STEP) begin
            err_d = 1'b1;
        end
    end

    assign COIL     = coil_q;
    assign BUSY     = busy_q;
    assign STEP_ERR = err_q;
    assign POS      = pos_q;

endmodule
